// File: rtl/mdu_ctrl_if.sv
// E-stage to MDU bundle: instruction operands in, status/HI/LO/mfhi-mflo data out.
// Handshake: an op issues on the rising edge where e_valid=1, ext_stall=0, busy=0 and e_md_op is 1..6.
interface mdu_ctrl_if;
    logic        e_valid;
    logic        ext_stall;
    logic [3:0]  e_md_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        busy;
    logic        stall_req;
    logic [31:0] mdu_out;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output e_valid, ext_stall, e_md_op, e_rs, e_rt,
        input  busy, stall_req, mdu_out, hi, lo
    );

    modport slave (
        input  e_valid, ext_stall, e_md_op, e_rs, e_rt,
        output busy, stall_req, mdu_out, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; the result is computed at issue
// and held pending until the latency down-counter expires.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_ctrl_if.slave bus,
    output logic      state_dbg
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          busy_r;
    logic [31:0]   hi_r, lo_r;
    logic [31:0]   hi_pend, lo_pend;
    logic          pend_wr;

    logic          is_start, is_issue_op, is_md_op, issue;
    logic [63:0]   smul, umul;
    logic [31:0]   res_hi, res_lo;
    logic          res_wr;

    assign is_start    = (bus.e_md_op >= 4'd1) && (bus.e_md_op <= 4'd4);
    assign is_issue_op = (bus.e_md_op >= 4'd1) && (bus.e_md_op <= 4'd6);
    assign is_md_op    = (bus.e_md_op >= 4'd1) && (bus.e_md_op <= 4'd8);
    assign issue       = bus.e_valid & ~bus.ext_stall & ~busy_r & is_issue_op;

    assign smul = $signed({{32{bus.e_rs[31]}}, bus.e_rs}) * $signed({{32{bus.e_rt[31]}}, bus.e_rt});
    assign umul = {32'd0, bus.e_rs} * {32'd0, bus.e_rt};

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (bus.e_md_op)
            4'd1: {res_hi, res_lo} = smul;
            4'd2: {res_hi, res_lo} = umul;
            4'd3: begin
                if (bus.e_rt == 32'd0) begin
                    res_wr = 1'b0;
                end else if (bus.e_rs == 32'h8000_0000 && bus.e_rt == 32'hFFFF_FFFF) begin
                    // Signed overflow: quotient wraps to the dividend, remainder is zero.
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $signed(bus.e_rs) / $signed(bus.e_rt);
                    res_hi = $signed(bus.e_rs) % $signed(bus.e_rt);
                end
            end
            4'd4: begin
                if (bus.e_rt == 32'd0) begin
                    res_wr = 1'b0;
                end else begin
                    res_lo = bus.e_rs / bus.e_rt;
                    res_hi = bus.e_rs % bus.e_rt;
                end
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            hi_pend <= 32'd0;
            lo_pend <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (bus.e_md_op == 4'd5) hi_r <= bus.e_rs;
                        if (bus.e_md_op == 4'd6) lo_r <= bus.e_rs;
                        if (is_start) begin
                            hi_pend <= res_hi;
                            lo_pend <= res_lo;
                            pend_wr <= res_wr;
                            cnt     <= (bus.e_md_op <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                            busy_r  <= 1'b1;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == CW'(1)) begin
                        if (pend_wr) begin
                            hi_r <= hi_pend;
                            lo_r <= lo_pend;
                        end
                        pend_wr <= 1'b0;
                        cnt     <= '0;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;
    assign bus.stall_req = bus.e_valid & busy_r & is_md_op;
    assign bus.mdu_out   = (bus.e_md_op == 4'd7) ? hi_r :
                           (bus.e_md_op == 4'd8) ? lo_r : 32'd0;
    assign state_dbg     = (state == BUSY);
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: scoreboard of expected {HI,LO} per mult/div op.
module tb_mdu_ctrl;
    logic clk;
    logic reset;
    logic state_dbg;
    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // reference models
    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        if (sgn && a[31]) p = p - {b, 32'd0};
        if (sgn && b[31]) p = p - {a, 32'd0};
        return p;
    endfunction

    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn, input logic [63:0] prev);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return prev;
        if (!sgn) return {a % b, a / b};
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
    endfunction

    // driver: caller is positioned at a negedge; returns at the negedge where busy has fallen
    task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input string name);
        logic [63:0] e, got;
        int          n_exp, cycles;
        if (op <= 4'd2) begin
            e = model_mul(rs, rt, op == 4'd1);
            n_exp = 5;
        end else begin
            e = model_div(rs, rt, op == 4'd3, {m_hi, m_lo});
            n_exp = 10;
        end
        exp_q.push_back(e);
        {m_hi, m_lo} = e;
        bus.e_valid = 1'b1; bus.e_md_op = op; bus.e_rs = rs; bus.e_rt = rt;
        @(negedge clk);
        bus.e_valid = 1'b0; bus.e_md_op = 4'd0;
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 64) begin
            cycles++;
            @(negedge clk);
        end
        n_cmp++;
        if (cycles !== n_exp) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, cycles, n_exp);
        end
        got = {bus.hi, bus.lo};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s hilo: got %h expected %h", name, got, e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.e_valid = 1'b0; bus.ext_stall = 1'b0; bus.e_md_op = 4'd0;
        bus.e_rs = 32'd0; bus.e_rt = 32'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.stall_req, state_dbg, bus.hi, bus.lo, bus.mdu_out} !== 99'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b stall=%b st=%b hi=%h lo=%h out=%h expected all zero",
                     bus.busy, bus.stall_req, state_dbg, bus.hi, bus.lo, bus.mdu_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, "mult");
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, "multu");
    endtask

    task automatic test_div();
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
        run_op(4'd4, 32'd7, 32'd0, "divu_zero");
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(4'd3, 32'd5, 32'd0, "div_zero");
    endtask

    task automatic test_no_issue();
        bus.e_valid = 1'b0; bus.e_md_op = 4'd1; bus.e_rs = 32'd9; bus.e_rt = 32'd9;
        @(negedge clk);
        bus.e_valid = 1'b1; bus.e_md_op = 4'd9;
        @(negedge clk);
        bus.e_md_op = 4'd3; bus.ext_stall = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== {m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL no_issue: got busy=%b hilo=%h expected busy=0 hilo=%h", bus.busy, {bus.hi, bus.lo}, {m_hi, m_lo});
        end
        bus.e_valid = 1'b0; bus.ext_stall = 1'b0; bus.e_md_op = 4'd0;
    endtask

    task automatic test_mflo_stall();
        logic [63:0] e;
        int          cycles;
        e = model_mul(32'd5, 32'd7, 1'b1);
        exp_q.push_back(e);
        {m_hi, m_lo} = e;
        bus.e_valid = 1'b1; bus.e_md_op = 4'd1; bus.e_rs = 32'd5; bus.e_rt = 32'd7;
        @(negedge clk);
        bus.e_md_op = 4'd8;
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 64) begin
            n_cmp++;
            if (bus.stall_req !== 1'b1) begin
                n_fail++;
                $display("FAIL mflo_stall_busy: got %b expected 1 (cycle %0d)", bus.stall_req, cycles);
            end
            cycles++;
            bus.ext_stall = cycles[0];
            @(negedge clk);
        end
        bus.ext_stall = 1'b0;
        #1;
        n_cmp++;
        if (cycles !== 5 || bus.stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mflo_stall_release: got cycles=%0d stall=%b expected 5 / 0", cycles, bus.stall_req);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.mdu_out !== e[31:0]) begin
            n_fail++;
            $display("FAIL mflo_value: got %h expected %h", bus.mdu_out, e[31:0]);
        end
        bus.e_valid = 1'b0; bus.e_md_op = 4'd0;
    endtask

    task automatic test_mthi_ext_stall();
        bus.e_valid = 1'b1; bus.e_md_op = 4'd5; bus.e_rs = 32'h1234_5678; bus.ext_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.hi !== m_hi || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mthi_stalled: got hi=%h busy=%b expected hi=%h busy=0", bus.hi, bus.busy, m_hi);
            end
        end
        bus.ext_stall = 1'b0;
        @(negedge clk);
        m_hi = 32'h1234_5678;
        bus.e_valid = 1'b0; bus.e_rs = 32'hDEAD_BEEF;
        n_cmp++;
        if (bus.hi !== m_hi || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_release: got hi=%h busy=%b expected hi=%h busy=0", bus.hi, bus.busy, m_hi);
        end
        @(negedge clk);
        bus.e_valid = 1'b1; bus.e_md_op = 4'd6; bus.e_rs = 32'hA5A5_0F0F;
        @(negedge clk);
        m_lo = 32'hA5A5_0F0F;
        bus.e_valid = 1'b0; bus.e_md_op = 4'd0;
        n_cmp++;
        if ({bus.hi, bus.lo, bus.busy} !== {m_hi, m_lo, 1'b0}) begin
            n_fail++;
            $display("FAIL mtlo_write: got hi=%h lo=%h busy=%b expected %h %h 0", bus.hi, bus.lo, bus.busy, m_hi, m_lo);
        end
    endtask

    task automatic test_back_to_back();
        run_op(4'd2, 32'h0001_0000, 32'h0001_0000, "b2b_multu");
        run_op(4'd4, 32'd100, 32'd7, "b2b_divu");
        run_op(4'd1, 32'h8000_0000, 32'h8000_0000, "b2b_mult");
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] rs, rt;
        for (int i = 0; i < 6; i++) begin
            op = 4'($urandom_range(1, 4));
            rs = $urandom;
            rt = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op(op, rs, rt, "random");
        end
    endtask

    task automatic test_reset_busy();
        bus.e_valid = 1'b1; bus.e_md_op = 4'd3; bus.e_rs = 32'd100; bus.e_rt = 32'd7;
        @(negedge clk);
        bus.e_valid = 1'b0; bus.e_md_op = 4'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy_pre: got busy=%b expected 1", bus.busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        bus.e_valid = 1'b1; bus.e_md_op = 4'd7;
        #1;
        n_cmp++;
        if ({bus.busy, bus.hi, bus.lo, bus.mdu_out, bus.stall_req} !== 98'd0) begin
            n_fail++;
            $display("FAIL reset_busy_post: got busy=%b hi=%h lo=%h out=%h stall=%b expected all zero",
                     bus.busy, bus.hi, bus.lo, bus.mdu_out, bus.stall_req);
        end
        repeat (12) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.hi, bus.lo} !== 65'd0) begin
            n_fail++;
            $display("FAIL reset_busy_late: got busy=%b hi=%h lo=%h expected zero", bus.busy, bus.hi, bus.lo);
        end
        bus.e_valid = 1'b0; bus.e_md_op = 4'd0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_no_issue();
        test_mflo_stall();
        test_mthi_ext_stall();
        test_back_to_back();
        test_random();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
